// File: rtl/branch_pkg.sv
// Shared branch-resolution definitions: funct3 codes, BHT counter type and update rule.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_RESET = 2'b01;

  // Saturating 2-bit counter step: taken counts up to 11, not-taken down to 00.
  function automatic bht_cnt_t bht_next(bht_cnt_t cnt, logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken && cnt != 2'b11) begin
      nxt = cnt + 2'b01;
    end else if (!taken && cnt != 2'b00) begin
      nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational RISC-V conditional-branch evaluator: funct3 and operands to taken/illegal.
module branch_compare
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_data == rs2_data);
  assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
  assign lt_u = (rs1_data < rs2_data);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: one-cycle registered outcome, mispredict flag and 2-bit BHT.
// Optional BRANCH_STATS_EN adds 32-bit resolved-branch and mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            stall,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            out_valid,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             cmp_taken;
  logic             cmp_illegal;
  logic             bht_we;
  logic             mispredict;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lk_idx;
  bht_cnt_t         bht_q [DEPTH];

  logic out_valid_q;
  logic out_taken_q;
  logic out_mispredict_q;
  logic out_illegal_q;

  branch_compare #(
    .XLEN (XLEN)
  ) u_compare (
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (cmp_taken),
    .illegal  (cmp_illegal)
  );

  // Word-aligned index; upper PC bits alias by design.
  assign upd_idx    = pc[IDX_W+1:2];
  assign lk_idx     = lookup_pc[IDX_W+1:2];
  assign bht_we     = in_valid & ~stall & ~cmp_illegal;
  assign mispredict = in_valid & ~cmp_illegal & (cmp_taken ^ pred_taken);

  // Read is from the current array state, so a same-cycle update is not visible.
  assign lookup_taken = bht_q[lk_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else if (bht_we) begin
      bht_q[upd_idx] <= bht_next(bht_q[upd_idx], cmp_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
      out_illegal_q    <= 1'b0;
    end else if (!stall) begin
      out_valid_q      <= in_valid;
      out_taken_q      <= in_valid & cmp_taken;
      out_mispredict_q <= mispredict;
      out_illegal_q    <= in_valid & cmp_illegal;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_mispredict = out_mispredict_q;
  assign out_illegal    = out_illegal_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (bht_we) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[XLEN-1:IDX_W+2], pc[1:0],
                            lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomised bench for branch_resolve_unit with a scoreboard and BHT model.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic [2:0]  funct3;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] pc;
  logic        pred_taken;
  logic [63:0] lookup_pc;
  logic        lookup_taken;
  logic        out_valid;
  logic        out_taken;
  logic        out_mispredict;
  logic        out_illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  logic [31:0] m_branches;
  logic [31:0] m_mispredicts;
`endif

  typedef struct packed {
    logic v;
    logic t;
    logic m;
    logic i;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [1:0]  bht_m [64];
  int          total;
  int          bad;

  branch_resolve_unit #(
    .XLEN  (64),
    .DEPTH (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .stall          (stall),
    .funct3         (funct3),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .lookup_pc      (lookup_pc),
    .lookup_taken   (lookup_taken),
    .out_valid      (out_valid),
    .out_taken      (out_taken),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Signed order via sign-bit flip, independent of $signed.
  function automatic logic ref_taken(input logic [2:0] f, input logic [63:0] a,
                                     input logic [63:0] b);
    logic [63:0] as;
    logic [63:0] bs;
    as = a ^ 64'h8000_0000_0000_0000;
    bs = b ^ 64'h8000_0000_0000_0000;
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return as < bs;
      3'b101:  return as >= bs;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
`ifdef BRANCH_STATS_EN
    m_branches    = '0;
    m_mispredicts = '0;
`endif
  endtask

  // One clock of stimulus; lookup_pc follows the branch PC to probe the entry it trains.
  task automatic drive(input logic rst, input logic v, input logic st, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] p,
                       input logic pt, input string tag);
    exp_t e;
    logic legal;
    logic t;
    logic [5:0] idx;
    rst_n      = rst;
    in_valid   = v;
    stall      = st;
    funct3     = f;
    rs1_data   = a;
    rs2_data   = b;
    pc         = p;
    pred_taken = pt;
    lookup_pc  = p;
    idx   = p[7:2];
    legal = (f != 3'b010) && (f != 3'b011);
    t     = ref_taken(f, a, b);
    if (!rst)     e = '0;
    else if (st)  e = last;
    else if (!v)  e = '0;
    else          e = '{v: 1'b1, t: t, m: legal && (t != pt), i: !legal};
    sb.push_back(e);
    #2;
    chk({tag, "/lookup_pre"}, {63'd0, lookup_taken}, {63'd0, bht_m[idx][1]});
    @(posedge clk);
    if (!rst) begin
      reset_model();
    end else if (v && !st && legal) begin
      bht_m[idx] = sat(bht_m[idx], t);
`ifdef BRANCH_STATS_EN
      m_branches = m_branches + 32'd1;
      if (t != pt) m_mispredicts = m_mispredicts + 32'd1;
`endif
    end
    #1;
    e = sb.pop_front();
    chk({tag, "/valid"}, {63'd0, out_valid}, {63'd0, e.v});
    if (e.v || !rst) begin
      chk({tag, "/taken"}, {63'd0, out_taken}, {63'd0, e.t});
      chk({tag, "/mispredict"}, {63'd0, out_mispredict}, {63'd0, e.m});
      chk({tag, "/illegal"}, {63'd0, out_illegal}, {63'd0, e.i});
    end
    last = e;
    chk({tag, "/lookup_post"}, {63'd0, lookup_taken}, {63'd0, bht_m[idx][1]});
`ifdef BRANCH_STATS_EN
    chk({tag, "/stat_br"}, {32'd0, stat_branches}, {32'd0, m_branches});
    chk({tag, "/stat_mp"}, {32'd0, stat_mispredicts}, {32'd0, m_mispredicts});
`endif
  endtask

  initial begin
    logic [2:0]  rf;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] rp;
    total = 0;
    bad   = 0;
    last  = '0;
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; funct3 = 3'b000;
    rs1_data = '0; rs2_data = '0; pc = '0; pred_taken = 1'b0; lookup_pc = '0;
    repeat (2) @(posedge clk);
    reset_model();
    #1;

    // 1: reset state, lookup at 0x100, idle cycle after release
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'h100, 1'b0, "rst");
    drive(1'b1, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'h100, 1'b0, "post_rst");

    // 2: signed vs unsigned on -1 vs 1
    drive(1'b1, 1'b1, 1'b0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h80, 1'b0, "blt");
    drive(1'b1, 1'b1, 1'b0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h80, 1'b0, "bltu");

    // 3: train entry 0x40 up to saturation then back down
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 1'b0, 3'b000, 64'h55, 64'h55, 64'h40, 1'b0, "beq_t");
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 1'b0, 3'b000, 64'h55, 64'h56, 64'h40, 1'b0, "beq_nt");

    // 4: illegal on an entry at 10, so any wrongful update flips the MSB
    drive(1'b1, 1'b1, 1'b0, 3'b001, 64'd1, 64'd2, 64'h48, 1'b1, "bne_train");
    drive(1'b1, 1'b1, 1'b0, 3'b010, 64'd1, 64'd1, 64'h48, 1'b1, "illegal");
    drive(1'b1, 1'b1, 1'b0, 3'b011, 64'd1, 64'd2, 64'h48, 1'b0, "illegal3");

    // 5: stall holds outputs and BHT, then result appears one cycle after release
    drive(1'b1, 1'b1, 1'b1, 3'b001, 64'd7, 64'd9, 64'h4C, 1'b0, "stall0");
    drive(1'b1, 1'b1, 1'b1, 3'b001, 64'd7, 64'd9, 64'h4C, 1'b0, "stall1");
    drive(1'b1, 1'b1, 1'b0, 3'b001, 64'd7, 64'd9, 64'h4C, 1'b0, "unstall");
    drive(1'b1, 1'b0, 1'b0, 3'b001, 64'd7, 64'd9, 64'h4C, 1'b0, "idle");

    // 6: reset beats a valid taken BGE on a trained entry
    drive(1'b1, 1'b1, 1'b0, 3'b101, 64'd5, 64'd5, 64'h50, 1'b0, "bge_train");
    drive(1'b0, 1'b1, 1'b0, 3'b101, 64'd5, 64'd5, 64'h50, 1'b0, "bge_rst");
    drive(1'b1, 1'b0, 1'b0, 3'b101, 64'd5, 64'd5, 64'h50, 1'b0, "bge_after");

    // Randomised mix, including aliasing PCs and stalls
    for (int n = 0; n < 60; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 2) == 0) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rb[63] = ~ra[63];
      rp = 64'h1000 + 64'($urandom_range(0, 7) << 2) + 64'($urandom_range(0, 1) << 8);
      drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), rf, ra, rb,
            rp, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
